// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared FSM state type and default operand width for mult_arbiter
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker searching upward from last_owner+1
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    // k runs 1..NUM_REQ so last_owner itself is considered last
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one multiplier among NUM_REQ requesters
// Optional WAIT watchdog enabled by defining MULT_ARBITER_TIMEOUT_EN.
module mult_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*WIDTH-1:0] req_in2,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [2*WIDTH-1:0]       result,
  output logic                     err,
  output logic                     busy,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_in1,
  output logic [WIDTH-1:0]         mult_in2,
  input  logic [2*WIDTH-1:0]       mult_out,
  input  logic                     mult_finish
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic [WIDTH-1:0]     in1_q, in1_d, in2_q, in2_d;
  logic [IDXW-1:0]      last_owner_q, last_owner_d;
  logic [IDXW-1:0]      owner_q, owner_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic                 pick_valid;
  logic [IDXW-1:0]      pick_idx;
  logic [WIDTH-1:0]     pick_in1, pick_in2;

`ifdef MULT_ARBITER_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr_picker (
    .req        (req),
    .last_owner (last_owner_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    pick_in1 = '0;
    pick_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx = IDXW'(i);
        pick_in1 = req_in1[i*WIDTH +: WIDTH];
        pick_in2 = req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = '0;
    result_d     = result_q;
    start_d      = 1'b0;
    in1_d        = in1_q;
    in2_d        = in2_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
`ifdef MULT_ARBITER_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          in1_d   = pick_in1;
          in2_d   = pick_in2;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef MULT_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mult_finish) begin
          result_d = mult_out;
          done_d   = grant_q;
          state_d  = ST_DONE;
`ifdef MULT_ARBITER_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = grant_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
`endif
        end
      end
      ST_DONE: begin
        last_owner_d = owner_q;
        grant_d      = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      last_owner_q <= IDXW'(NUM_REQ - 1);
      owner_q      <= '0;
`ifdef MULT_ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
`ifdef MULT_ARBITER_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign result     = result_q;
  assign busy       = busy_q;
  assign mult_start = start_q;
  assign mult_in1   = in1_q;
  assign mult_in2   = in2_q;
`ifdef MULT_ARBITER_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter with a fixed-latency multiplier model
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_in1 = '0;
  logic [15:0] req_in2 = '0;
  logic [1:0]  grant, done;
  logic [15:0] result;
  logic        err, busy, mult_start;
  logic [7:0]  mult_in1, mult_in2;
  logic [15:0] mult_out;
  logic        mult_finish;

  logic        model_en = 1'b1;
  logic        mf_manual = 1'b0;
  logic [15:0] mo_manual = '0;
  logic        mf_model = 1'b0;
  logic [15:0] mo_model = '0;
  logic        pend = 1'b0;
  int          lat_cnt = 0;
  int          start_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  assign mult_finish = model_en ? mf_model : mf_manual;
  assign mult_out    = model_en ? mo_model : mo_manual;

  always #5 clk = ~clk;

  mult_arbiter #(
    .WIDTH          (8),
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .grant       (grant),
    .done        (done),
    .result      (result),
    .err         (err),
    .busy        (busy),
    .mult_start  (mult_start),
    .mult_in1    (mult_in1),
    .mult_in2    (mult_in2),
    .mult_out    (mult_out),
    .mult_finish (mult_finish)
  );

  // Multiplier with 5-cycle latency from the start pulse to the finish pulse
  always @(posedge clk) begin
    mf_model <= 1'b0;
    if (mult_start) start_cnt <= start_cnt + 1;
    if (rst) begin
      pend <= 1'b0;
    end else if (mult_start) begin
      pend     <= 1'b1;
      lat_cnt  <= 4;
      mo_model <= 16'(mult_in1) * 16'(mult_in2);
    end else if (pend) begin
      if (lat_cnt == 0) begin
        mf_model <= 1'b1;
        pend     <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    while (mult_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", mult_start, 1);
  endtask

  task automatic wait_done(output int cycles, output logic fin_prev);
    int n = 0;
    fin_prev = 1'b0;
    while (done == 2'b00 && n < 300) begin
      fin_prev = mult_finish;
      @(negedge clk);
      n++;
    end
    cycles = n;
    check_eq("done_seen", done != 2'b00, 1);
  endtask

  initial begin
    int   cyc;
    logic fp;
    int   s0;
    logic [1:0] exp_g;

    do_reset();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", mult_start, 0);
    check_eq("rst_in1", mult_in1, 0);
    check_eq("rst_in2", mult_in2, 0);

    // Single requester 13*11
    req = 2'b01; req_in1 = {8'd0, 8'd13}; req_in2 = {8'd0, 8'd11};
    s0 = start_cnt;
    @(negedge clk);
    check_eq("t1_grant", grant, 2'b01);
    check_eq("t1_start", mult_start, 1);
    check_eq("t1_in1", mult_in1, 13);
    @(negedge clk);
    check_eq("t1_start_pulse", mult_start, 0);
    wait_done(cyc, fp);
    check_eq("t1_done", done, 2'b01);
    check_eq("t1_done_lat", fp, 1);
    check_eq("t1_result", result, 143);
    check_eq("t1_err", err, 0);
    req = 2'b00;
    @(negedge clk);
    check_eq("t1_done_pulse", done, 0);
    check_eq("t1_grant_clr", grant, 0);
    check_eq("t1_starts", start_cnt - s0, 1);

    // Both requesting continuously: 3*5 and 7*9 alternate
    do_reset();
    req = 2'b11; req_in1 = {8'd7, 8'd3}; req_in2 = {8'd9, 8'd5};
    wait_start();
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      check_eq("t2_grant", grant, exp_g);
      check_eq("t2_in1", mult_in1, (i % 2 == 1) ? 7 : 3);
      wait_done(cyc, fp);
      check_eq("t2_done", done, exp_g);
      check_eq("t2_result", result, (i % 2 == 1) ? 63 : 15);
      if (i == 3) req = 2'b00;
      @(negedge clk);
      check_eq("t2_gap_grant", grant, 0);
      if (i < 3) begin
        @(negedge clk);
        check_eq("t2_restart", mult_start, 1);
      end
    end

    // Owner withdraws and changes operands mid-operation
    do_reset();
    req = 2'b01; req_in1 = {8'd0, 8'd255}; req_in2 = {8'd0, 8'd255};
    wait_start();
    @(negedge clk);
    req = 2'b00; req_in1 = '0;
    repeat (2) @(negedge clk);
    check_eq("t3_in1_wait", mult_in1, 255);
    wait_done(cyc, fp);
    check_eq("t3_done", done, 2'b01);
    check_eq("t3_result", result, 65025);
    check_eq("t3_in1_done", mult_in1, 255);

    // Reset in WAIT, late finish afterwards
    do_reset();
    model_en = 1'b0;
    req = 2'b01; req_in1 = {8'd0, 8'd13}; req_in2 = {8'd0, 8'd11};
    wait_start();
    repeat (2) @(negedge clk);
    check_eq("t4_busy_wait", busy, 1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t4_busy_rst", busy, 0);
    mf_manual = 1'b1; mo_manual = 16'd143;
    @(negedge clk);
    mf_manual = 1'b0;
    check_eq("t4_done", done, 0);
    check_eq("t4_result", result, 0);
    check_eq("t4_busy", busy, 0);
    @(negedge clk);
    check_eq("t4_done_late", done, 0);

    // Spurious finish in IDLE then in ISSUE
    mf_manual = 1'b1; mo_manual = 16'd999;
    @(negedge clk);
    mf_manual = 1'b0;
    check_eq("t5_idle_result", result, 0);
    check_eq("t5_idle_done", done, 0);
    req = 2'b01; req_in1 = {8'd0, 8'd2}; req_in2 = {8'd0, 8'd3};
    @(negedge clk);
    check_eq("t5_issue", mult_start, 1);
    mf_manual = 1'b1; mo_manual = 16'd1234;
    @(negedge clk);
    mf_manual = 1'b0;
    check_eq("t5_issue_result", result, 0);
    check_eq("t5_issue_done", done, 0);
    check_eq("t5_busy", busy, 1);
    mf_manual = 1'b1; mo_manual = 16'd6;
    @(negedge clk);
    mf_manual = 1'b0; req = 2'b00;
    check_eq("t5_done", done, 2'b01);
    check_eq("t5_result", result, 6);
    @(negedge clk);

`ifdef MULT_ARBITER_TIMEOUT_EN
    // Multiplier never finishes: watchdog after 8 WAIT cycles
    do_reset();
    model_en = 1'b0;
    req = 2'b01; req_in1 = {8'd0, 8'd4}; req_in2 = {8'd0, 8'd4};
    wait_start();
    wait_done(cyc, fp);
    check_eq("t6_cycles", cyc, 9);
    check_eq("t6_done", done, 2'b01);
    check_eq("t6_err", err, 1);
    check_eq("t6_result", result, 0);
    req = 2'b00;
    @(negedge clk);
    model_en = 1'b1;
    req = 2'b01; req_in1 = {8'd0, 8'd3}; req_in2 = {8'd0, 8'd5};
    wait_start();
    wait_done(cyc, fp);
    check_eq("t6_next_result", result, 15);
    check_eq("t6_next_err", err, 0);
    req = 2'b00;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, operand width; NUM_REQ, default 2, requester count; TIMEOUT_CYCLES, default 64, watchdog limit.
REQ-002 There SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester level request
- req_in1  in  NUM_REQ*WIDTH  flattened operand A; slice i belongs to requester i
- req_in2  in  NUM_REQ*WIDTH  flattened operand B
- grant  out  NUM_REQ  one-hot; current owner
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- result  out  2*WIDTH  product; held until the next completion
- err  out  1  timeout flag; qualified by done
- busy  out  1  high when state is not IDLE
- mult_start  out  1  one-cycle start pulse to the shared multiplier
- mult_in1, mult_in2  out  WIDTH each  latched operands to the multiplier
- mult_out  in  2*WIDTH  multiplier product
- mult_finish  in  1  multiplier completion pulse

Function
REQ-004 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, with all outputs registered.
REQ-005 IDLE: if any req bit is high, the block SHALL pick a winner round-robin, searching from (last_owner+1) mod NUM_REQ upward; latch that requester's slices into mult_in1/mult_in2; set grant; then go to ISSUE.
REQ-006 ISSUE SHALL assert mult_start for exactly one cycle and then go to WAIT.
REQ-007 WAIT: on mult_finish, the block SHALL capture mult_out into result and go to DONE. mult_finish SHALL be ignored in every state except WAIT.
REQ-008 DONE SHALL:
- pulse done[owner] for one cycle;
- update last_owner to the owner;
- return to IDLE, clearing grant on entry to IDLE.
REQ-009 Latency:
- req sampled in IDLE at cycle t gives grant and mult_start at t+1;
- mult_finish at cycle k gives done and result at k+1;
- grant is low at k+2;
- the earliest next mult_start is at k+3.
REQ-010 mult_in1/mult_in2 SHALL stay stable from ISSUE through DONE, whatever happens on req_in* meanwhile.
REQ-011 If the owner drops req after grant, the operation SHALL still complete and done SHALL still pulse. Requests are never aborted.
REQ-012 A requester SHALL drop req in the cycle after its done; a req still high in IDLE is treated as a new request.
REQ-013 If only one requester is active, it SHALL be re-granted on every arbitration; there is no forced idle beyond REQ-009.
REQ-014 Multiplication SHALL be unsigned, and result SHALL be the full 2*WIDTH bits with no truncation.

Reset
REQ-015 When rst is high at a clock edge, the block SHALL go to IDLE and set:
- grant=0, done=0, result=0, err=0, busy=0, mult_start=0;
- mult_in1=0, mult_in2=0;
- last_owner=NUM_REQ-1, so that requester 0 has first priority.
REQ-016 Reset asserted mid-operation SHALL abandon the operation with no done pulse; a late mult_finish after reset SHALL be ignored.

Configuration
REQ-017 With MULT_ARBITER_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT and increment each WAIT cycle;
- if it reaches TIMEOUT_CYCLES without mult_finish, the block SHALL go to DONE with err=1 and result=0, and done SHALL pulse normally.
REQ-018 Without MULT_ARBITER_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-019 Shared package rsa_pkg SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-020 Round-robin selection SHALL live in one combinational sub-module, rr_picker (inputs req and last_owner; outputs one-hot grant and a valid flag), instantiated once.

Verification
REQ-021 After reset, req=2'b01, in1=13, in2=11, and a multiplier model with 5-cycle latency → grant=01, mult_start one pulse, done[0] one pulse, result=143, err=0.
REQ-022 req=2'b11 held continuously, with requester 0 operands 3*5 and requester 1 operands 7*9 → grants alternate 01,10,01,...; results alternate 15,63.
REQ-023 Owner drops req and changes req_in1 to 0 during WAIT, operands 255*255 → mult_in1 stays 255, done pulses, result=65025.
REQ-024 rst asserted in WAIT, then mult_finish pulsed one cycle after reset → no done, state IDLE, result=0.
REQ-025 With MULT_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a multiplier that never finishes → done pulses with err=1 and result=0, and the next request is serviced normally.
REQ-026 A spurious mult_finish during IDLE or ISSUE → ignored, and result is unchanged.
